muldiv_seq: RTL and testbench

- Multi-cycle multiply/divide sequencer that takes MUL and DIV work off the single-cycle ALU and owns the architectural Hi/Lo registers.
- Accepts one operation per start pulse, runs iterative shift-add multiply or restoring divide over N cycles, then writes Hi/Lo and pulses done.
- Sits beside the ALU in the execute stage; the pipeline control uses busy to stall MFHI/MFLO and back-to-back MUL/DIV.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_seq.sv | 163 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes and sequencer state type for muldiv_seq
package muldiv_pkg;

  // ALU decode values that route work to the multiply/divide sequencer
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring divide iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  muldiv_state_t  op_i,
  input  logic [2*N-1:0] acc_i,
  input  logic [N-1:0]   operand_i,
  output logic [2*N-1:0] acc_o,
  output logic           q_bit_o
);

  // MUL: acc = {partial product, remaining multiplier bits}.
  // DIV: acc = {partial remainder, remaining dividend / quotient bits}.
  // The remainder always stays below the divisor, so N bits hold it and
  // only the shifted value needs the extra top bit for the compare.
  logic [N:0]   sum;
  logic [N:0]   shifted;
  logic [N-1:0] diff;

  // Compute both candidate iterations and select by operation
  always_comb begin
    sum     = {1'b0, acc_i[2*N-1:N]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    shifted = {acc_i[2*N-1:N], acc_i[N-1]};
    diff    = shifted[N-1:0] - operand_i;
    q_bit_o = (shifted >= {1'b0, operand_i});
    if (op_i == DIV) begin
      // Quotient bit slot is left clear; the sequencer inserts q_bit_o
      acc_o = {(q_bit_o ? diff : shifted[N-1:0]), acc_i[N-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[N-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MUL/DIV sequencer owning Hi/Lo; MULDIV_SIGNED_EN adds signed_op
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
`ifdef MULDIV_SIGNED_EN
  input  logic         signed_op,
`endif
  input  logic [3:0]   alu_decode,
  input  logic [N-1:0] rda,
  input  logic [N-1:0] rdx,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Hi,
  output logic [N-1:0] Lo,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);

  muldiv_state_t  state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           dz_q, dz_d;

  logic [2*N-1:0] step_acc;
  logic           step_qbit;
  logic [2*N-1:0] result;
  logic [2*N-1:0] fin;
  logic [N-1:0]   mag_a, mag_x;

`ifdef MULDIV_SIGNED_EN
  logic neg_p_q, neg_p_d;
  logic neg_r_q, neg_r_d;

  // Iterations run on magnitudes; signs are re-applied when results land
  always_comb begin
    mag_a   = (signed_op && rda[N-1]) ? -rda : rda;
    mag_x   = (signed_op && rdx[N-1]) ? -rdx : rdx;
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      neg_p_d = signed_op && (rda[N-1] ^ rdx[N-1]);
      neg_r_d = signed_op && rda[N-1];
    end
  end

  // Sign flags captured with the operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  assign mag_a = rda;
  assign mag_x = rdx;
`endif

  muldiv_step #(.N(N)) u_step (
    .op_i      (state_q),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (step_acc),
    .q_bit_o   (step_qbit)
  );

  // Next state, iteration bookkeeping and Hi/Lo write-back
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    result  = (state_q == DIV) ? {step_acc[2*N-1:1], step_qbit} : step_acc;
    fin     = result;
`ifdef MULDIV_SIGNED_EN
    if (state_q == MUL) begin
      if (neg_p_q) fin = -result;
    end else begin
      if (neg_p_q) fin[N-1:0]   = -result[N-1:0];
      if (neg_r_q) fin[2*N-1:N] = -result[2*N-1:N];
    end
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (alu_decode == OP_MUL) begin
            state_d = MUL;
            cnt_d   = '0;
            opnd_d  = mag_a;
            acc_d   = {{N{1'b0}}, mag_x};
          end else if (alu_decode == OP_DIV) begin
            if (rdx == '0) begin
              // Divide by zero resolves immediately without iterating
              state_d = DONE;
              lo_d    = '1;
              hi_d    = rda;
              dz_d    = 1'b1;
            end else begin
              state_d = DIV;
              cnt_d   = '0;
              opnd_d  = mag_x;
              acc_d   = {{N{1'b0}}, mag_a};
            end
          end
        end
      end
      MUL, DIV: begin
        acc_d = result;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          hi_d    = fin[2*N-1:N];
          lo_d    = fin[N-1:0];
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // State, datapath and architectural Hi/Lo registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q == MUL) || (state_q == DIV);
  assign done     = (state_q == DONE);
  assign Hi       = hi_q;
  assign Lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq (MULDIV_SIGNED_EN adds signed cases)
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   alu_decode;
  logic [N-1:0] rda, rdx;
  logic         busy, done, div_zero;
  logic [N-1:0] Hi, Lo;
`ifdef MULDIV_SIGNED_EN
  logic         sop;
`endif

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           busy_from = -1;
  int           busy_to = -2;
  int           busy_until = 0;
  logic [N-1:0] m_hi = '0;
  logic [N-1:0] m_lo = '0;

  muldiv_seq #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef MULDIV_SIGNED_EN
    .signed_op  (sop),
`endif
    .alu_decode (alu_decode),
    .rda        (rda),
    .rdx        (rdx),
    .busy       (busy),
    .done       (done),
    .Hi         (Hi),
    .Lo         (Lo),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: busy against the model window, done against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      check("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_to));
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("hi", 64'(Hi), 64'(mon_e.hi));
          check("lo", 64'(Lo), 64'(mon_e.lo));
          check("div_zero", 64'(div_zero), 64'(mon_e.dz));
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        check("done_missing", 64'(done), 64'(1));
        void'(sb.pop_front());
      end
    end
  end

  // Drive one request for one cycle; the model decides acceptance and result
  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] x);
    exp_t   e;
    logic [63:0] p;
    longint sa, sx, q, r;
    int     m;
    bit     s;
    m = cyc;
    start = 1'b1;
    alu_decode = op;
    rda = a;
    rdx = x;
    if (m >= busy_until && (op == OP_MUL || op == OP_DIV)) begin
      s = 1'b0;
`ifdef MULDIV_SIGNED_EN
      s = sop;
`endif
      sa = s ? longint'($signed(a)) : longint'({32'b0, a});
      sx = s ? longint'($signed(x)) : longint'({32'b0, x});
      e.dz = 1'b0;
      e.cyc = m + 1 + N;
      if (op == OP_MUL) begin
        p = 64'(sa * sx);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end else if (x == '0) begin
        e.hi = a;
        e.lo = '1;
        e.dz = 1'b1;
        e.cyc = m + 1;
      end else begin
        q = sa / sx;
        r = sa % sx;
        e.lo = q[31:0];
        e.hi = r[31:0];
      end
      if (e.cyc != m + 1) begin
        busy_from = m + 1;
        busy_to = m + N;
      end
      busy_until = e.cyc;
      m_hi = e.hi;
      m_lo = e.lo;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    alu_decode = 4'b0;
  endtask

  task automatic goto_cyc(input int t);
    for (int i = 0; i < 200 && cyc < t; i++) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && cyc <= busy_until; i++) @(negedge clk);
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    int b0;
    int r;
    logic [3:0] op;
    reset = 1'b1;
    start = 1'b0;
    alu_decode = 4'b0;
    rda = '0;
    rdx = '0;
`ifdef MULDIV_SIGNED_EN
    sop = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(Hi), 64'(0));
    check("rst_lo", 64'(Lo), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    issue(OP_MUL, 32'd7, 32'd6);
    drain();
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    issue(OP_DIV, 32'd100, 32'd7);
    goto_cyc(busy_until);
    issue(OP_DIV, 32'd5, 32'd0);
    drain();

    issue(OP_MUL, 32'd3, 32'd4);
    b0 = busy_from;
    goto_cyc(b0 + 9);
    issue(OP_DIV, 32'd9, 32'd3);
    goto_cyc(busy_until);
    issue(OP_DIV, 32'd9, 32'd3);
    drain();

    issue(OP_MUL, 32'd123, 32'd456);
    b0 = busy_from;
    goto_cyc(b0 + 14);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_hi", 64'(Hi), 64'(0));
    check("arst_lo", 64'(Lo), 64'(0));
    check("arst_dz", 64'(div_zero), 64'(0));
    sb.delete();
    busy_from = -1;
    busy_to = -2;
    busy_until = 0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) @(negedge clk);
    issue(OP_MUL, 32'd2, 32'd2);
    drain();

    issue(4'b0001, 32'd11, 32'd13);
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("bad_op_hi", 64'(Hi), 64'(m_hi));
    check("bad_op_lo", 64'(Lo), 64'(m_lo));

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 5) ? OP_MUL : (r < 9) ? OP_DIV : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) goto_cyc(cyc + 2);
      else goto_cyc(busy_until + $urandom_range(0, 2));
      issue(op, pick(), pick());
    end
    drain();

`ifdef MULDIV_SIGNED_EN
    sop = 1'b1;
    issue(OP_MUL, -32'sd7, 32'd3);
    drain();
    issue(OP_DIV, -32'sd7, 32'd2);
    drain();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    drain();
    for (int n = 0; n < 12; n++) begin
      goto_cyc(busy_until + $urandom_range(0, 2));
      issue(($urandom_range(0, 1) == 1) ? OP_MUL : OP_DIV, pick(), pick());
    end
    drain();
    sop = 1'b0;
`endif

    for (int i = 0; i < 3; i++) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
